// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: turns 32-bit LDR/STR requests into two half-word accesses
// on a 16-bit async SRAM, stalling the pipeline through 'ready' while an access runs.
module mem_stage_sram_ctrl #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        Val_Rm,
  output logic               ready,
  output logic [31:0]        MEM_result,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic [1:0]         dbg_state
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          op_wr;
  logic [31:0]   wdata;
  logic [15:0]   lo_data;
  logic [31:0]   offs;
  logic          req;
  logic          last;
  logic          dq_oe;
  logic          unused_offs;

  assign offs        = ALU_result - 32'(BASE_ADDR);
  assign unused_offs = ^{offs[31:SRAM_AW+1], offs[1:0]};
  assign req         = MEM_R_EN | MEM_W_EN;
  assign last        = (cnt == CNT_LAST);
  assign dbg_state   = state;

  // Handshake: ready=1 means the pipeline may advance on this edge; the pipeline
  // holds MEM_*_EN, ALU_result and Val_Rm stable while ready=0.
  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nx = LO;
      end
      LO, HI: begin
        // WE_N rises one cycle before the window ends so data is held past the write.
        dq_oe     = op_wr;
        SRAM_WE_N = ~(op_wr & ~last);
        if (last) state_nx = (state == LO) ? HI : DONE;
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign SRAM_DQ = dq_oe ? ((state == HI) ? wdata[31:16] : wdata[15:0]) : 16'hzzzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      wdata      <= '0;
      lo_data    <= '0;
      MEM_result <= '0;
      SRAM_ADDR  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req) begin
            cnt       <= '0;
            op_wr     <= MEM_W_EN;
            wdata     <= Val_Rm;
            SRAM_ADDR <= {offs[SRAM_AW:2], 1'b0};
          end
        end
        LO: begin
          if (last) begin
            cnt          <= '0;
            SRAM_ADDR[0] <= 1'b1;
            if (!op_wr) lo_data <= SRAM_DQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HI: begin
          if (last) begin
            cnt <= '0;
            if (!op_wr) MEM_result <= {SRAM_DQ, lo_data};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
